// File: rtl/inst_encoder_pkg.sv
// Shared types and constants for the LEGv8 instruction encoder.
// Op enumeration, per-format opcodes, field widths, and immediate range helpers.
package inst_encoder_pkg;

    localparam int ADDR_W = 8;
    localparam int CNT_W  = ADDR_W + 1;
    localparam int WORD_W = 32;
    localparam int REG_W  = 5;
    localparam int IMM_W  = 26;
    localparam int OP_W   = 4;

    localparam int SHAMT_W = 6;
    localparam int IIMM_W  = 12;
    localparam int DIMM_W  = 9;
    localparam int CBIMM_W = 19;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 4'h0,
        OP_ADD  = 4'h1,
        OP_ORR  = 4'h2,
        OP_SUB  = 4'h3,
        OP_LSL  = 4'h4,
        OP_ADDI = 4'h5,
        OP_SUBI = 4'h6,
        OP_ANDI = 4'h7,
        OP_ORRI = 4'h8,
        OP_LDUR = 4'h9,
        OP_STUR = 4'hA,
        OP_B    = 4'hB,
        OP_CBZ  = 4'hC,
        OP_CBNZ = 4'hD,
        OP_RSVE = 4'hE,
        OP_RSVF = 4'hF
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } state_e;

    // R-format opcodes
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_LSL = 11'b11010011011;

    // I-format opcodes
    localparam logic [9:0] OPC_ADDI = 10'b1001000100;
    localparam logic [9:0] OPC_SUBI = 10'b1101000100;
    localparam logic [9:0] OPC_ANDI = 10'b1001001000;
    localparam logic [9:0] OPC_ORRI = 10'b1011001000;

    // D-, B- and CB-format opcodes
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [5:0]  OPC_B    = 6'b000101;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
    localparam logic [7:0]  OPC_CBNZ = 8'b10110101;

    // True when imm is representable as an unsigned value of 'bits' width.
    function automatic logic fits_unsigned(
        input logic [IMM_W-1:0] imm,
        input int unsigned      bits
    );
        logic [IMM_W-1:0] w_hi;
        w_hi = imm >> bits;
        return (w_hi == '0);
    endfunction

    // True when every bit above 'msb' equals imm[msb] (sign-extended fit).
    function automatic logic fits_signed(
        input logic [IMM_W-1:0] imm,
        input int unsigned      msb
    );
        logic signed [IMM_W-1:0] w_sh;
        w_sh = $signed(imm) >>> msb;
        return (w_sh == '0) || (w_sh == '1);
    endfunction

endpackage

// File: rtl/inst_encoder_pack.sv
// Combinational LEGv8 field packer: op plus operands to a 32-bit word.
// Flags illegal ops and immediates that do not fit their field.
module inst_pack
    import inst_encoder_pkg::*;
(
    input  logic [OP_W-1:0]   i_op,
    input  logic [REG_W-1:0]  i_rd,
    input  logic [REG_W-1:0]  i_rn,
    input  logic [REG_W-1:0]  i_rm,
    input  logic [IMM_W-1:0]  i_imm,
    output logic [WORD_W-1:0] o_word,
    output logic              o_illegal
);

    op_e w_op;
    logic w_fit_shamt;
    logic w_fit_i;
    logic w_fit_d;
    logic w_fit_cb;

    assign w_op        = op_e'(i_op);
    assign w_fit_shamt = fits_unsigned(i_imm, SHAMT_W);
    assign w_fit_i     = fits_unsigned(i_imm, IIMM_W);
    assign w_fit_d     = fits_signed(i_imm, DIMM_W - 1);
    assign w_fit_cb    = fits_signed(i_imm, CBIMM_W - 1);

    always_comb begin
        o_word    = '0;
        o_illegal = 1'b0;
        unique case (w_op)
            OP_AND: o_word = {OPC_AND, i_rm, 6'd0, i_rn, i_rd};
            OP_ADD: o_word = {OPC_ADD, i_rm, 6'd0, i_rn, i_rd};
            OP_ORR: o_word = {OPC_ORR, i_rm, 6'd0, i_rn, i_rd};
            OP_SUB: o_word = {OPC_SUB, i_rm, 6'd0, i_rn, i_rd};
            OP_LSL: begin
                o_word    = {OPC_LSL, 5'd0, i_imm[SHAMT_W-1:0], i_rn, i_rd};
                o_illegal = !w_fit_shamt;
            end
            OP_ADDI: begin
                o_word    = {OPC_ADDI, i_imm[IIMM_W-1:0], i_rn, i_rd};
                o_illegal = !w_fit_i;
            end
            OP_SUBI: begin
                o_word    = {OPC_SUBI, i_imm[IIMM_W-1:0], i_rn, i_rd};
                o_illegal = !w_fit_i;
            end
            OP_ANDI: begin
                o_word    = {OPC_ANDI, i_imm[IIMM_W-1:0], i_rn, i_rd};
                o_illegal = !w_fit_i;
            end
            OP_ORRI: begin
                o_word    = {OPC_ORRI, i_imm[IIMM_W-1:0], i_rn, i_rd};
                o_illegal = !w_fit_i;
            end
            OP_LDUR: begin
                o_word    = {OPC_LDUR, i_imm[DIMM_W-1:0], 2'b00, i_rn, i_rd};
                o_illegal = !w_fit_d;
            end
            OP_STUR: begin
                o_word    = {OPC_STUR, i_imm[DIMM_W-1:0], 2'b00, i_rn, i_rd};
                o_illegal = !w_fit_d;
            end
            OP_B: o_word = {OPC_B, i_imm};
            OP_CBZ: begin
                o_word    = {OPC_CBZ, i_imm[CBIMM_W-1:0], i_rd};
                o_illegal = !w_fit_cb;
            end
            OP_CBNZ: begin
                o_word    = {OPC_CBNZ, i_imm[CBIMM_W-1:0], i_rd};
                o_illegal = !w_fit_cb;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Encoder front end: accepts requests, packs them, and streams words into
// instruction memory at sequential addresses until 256 words are loaded.
module inst_encoder
    import inst_encoder_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   op,
    input  logic [REG_W-1:0]  rd,
    input  logic [REG_W-1:0]  rn,
    input  logic [REG_W-1:0]  rm,
    input  logic [IMM_W-1:0]  imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              err,
    output logic              full,
    output logic [CNT_W-1:0]  word_count
);

    state_e r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_count;
    logic              r_we;
    logic              r_err;
    logic              r_full;
    logic [ADDR_W-1:0] r_waddr;
    logic [WORD_W-1:0] r_wdata;

    logic [WORD_W-1:0] w_word;
    logic              w_illegal;
    logic              w_accept;
    logic              w_last;

    inst_pack u_pack (
        .i_op      (op),
        .i_rd      (rd),
        .i_rn      (rn),
        .i_rm      (rm),
        .i_imm     (imm),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

    assign in_ready = (r_state == ST_LOAD) && !start;
    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_addr == {ADDR_W{1'b1}});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_count <= '0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_full  <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_we  <= 1'b0;
            r_err <= 1'b0;
            if (start) begin
                r_state <= ST_LOAD;
                r_full  <= 1'b0;
                r_addr  <= '0;
                r_count <= '0;
            end else if (w_accept) begin
                if (w_illegal) begin
                    r_err <= 1'b1;
                end else begin
                    r_we    <= 1'b1;
                    r_waddr <= r_addr;
                    r_wdata <= w_word;
                    r_addr  <= r_addr + 1'b1;
                    r_count <= r_count + 1'b1;
                    if (w_last) begin
                        r_state <= ST_FULL;
                        r_full  <= 1'b1;
                    end
                end
            end
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_waddr;
    assign imem_wdata = r_wdata;
    assign err        = r_err;
    assign full       = r_full;
    assign word_count = r_count;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: encoding vectors, fill to FULL,
// start/reset corner cases, scoreboarded against a small behavioural model.
module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = '0;
    logic [4:0]  rd = '0;
    logic [4:0]  rn = '0;
    logic [4:0]  rm = '0;
    logic [25:0] imm = '0;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        err;
    logic        full;
    logic [8:0]  word_count;

    always #5 clk = ~clk;

    inst_encoder dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .rd         (rd),
        .rn         (rn),
        .rm         (rm),
        .imm        (imm),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .err        (err),
        .full       (full),
        .word_count (word_count)
    );

    typedef struct {
        logic        we;
        logic        err;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        full;
        logic [8:0]  cnt;
    } exp_t;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [25:0] imm;
        logic        bad;
        logic [31:0] word;
    } vec_t;

    exp_t q[$];
    vec_t vecs[$];

    int errors = 0;
    int checks = 0;

    // behavioural model: 0 idle, 1 load, 2 full
    int          m_state = 0;
    logic [7:0]  m_addr = '0;
    logic [8:0]  m_cnt = '0;
    logic [7:0]  m_last_addr = '0;
    logic [31:0] m_last_wdata = '0;

    task automatic step(
        input string       nm,
        input logic        rst,
        input logic        st,
        input logic        v,
        input logic [3:0]  o,
        input logic [4:0]  d,
        input logic [4:0]  n,
        input logic [4:0]  m,
        input logic [25:0] im,
        input logic        bad,
        input logic [31:0] word
    );
        exp_t e;
        exp_t g;
        logic exp_ready;
        logic acc;
        reset    = rst;
        start    = st;
        in_valid = v;
        op       = o;
        rd       = d;
        rn       = n;
        rm       = m;
        imm      = im;
        #1;
        exp_ready = (m_state == 1) && !st;
        checks++;
        if (in_ready !== exp_ready) begin
            errors++;
            $display("FAIL %s in_ready: got %b want %b", nm, in_ready, exp_ready);
        end
        acc   = v && exp_ready;
        e.we  = 1'b0;
        e.err = 1'b0;
        if (rst) begin
            m_state      = 0;
            m_addr       = '0;
            m_cnt        = '0;
            m_last_addr  = '0;
            m_last_wdata = '0;
        end else if (st) begin
            m_state = 1;
            m_addr  = '0;
            m_cnt   = '0;
        end else if (acc) begin
            if (bad) begin
                e.err = 1'b1;
            end else begin
                e.we         = 1'b1;
                m_last_addr  = m_addr;
                m_last_wdata = word;
                if (m_addr == 8'hFF) m_state = 2;
                m_addr = m_addr + 8'd1;
                m_cnt  = m_cnt + 9'd1;
            end
        end
        e.addr  = m_last_addr;
        e.wdata = m_last_wdata;
        e.full  = (m_state == 2);
        e.cnt   = m_cnt;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        g = q.pop_front();
        checks++;
        if (imem_we !== g.we || err !== g.err || imem_addr !== g.addr ||
            imem_wdata !== g.wdata || full !== g.full || word_count !== g.cnt) begin
            errors++;
            $display("FAIL %s outputs: got we=%b err=%b addr=%h wdata=%h full=%b cnt=%0d want we=%b err=%b addr=%h wdata=%h full=%b cnt=%0d",
                     nm, imem_we, err, imem_addr, imem_wdata, full, word_count,
                     g.we, g.err, g.addr, g.wdata, g.full, g.cnt);
        end
    endtask

    task automatic idle(input string nm);
        step(nm, 1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0, 32'd0);
    endtask

    initial begin
        vecs.push_back('{"add",      4'h1,  5'd1,  5'd2,  5'd3, 26'd0,         1'b0, 32'h8B030041});
        vecs.push_back('{"addi",     4'h5,  5'd9,  5'd9,  5'd0, 26'd1,         1'b0, 32'h91000529});
        vecs.push_back('{"addi_big", 4'h5,  5'd9,  5'd9,  5'd0, 26'd4096,      1'b1, 32'h0});
        vecs.push_back('{"ldur",     4'h9,  5'd10, 5'd1,  5'd0, 26'd8,         1'b0, 32'hF840802A});
        vecs.push_back('{"b_neg1",   4'hB,  5'd0,  5'd0,  5'd0, 26'h3FFFFFF,   1'b0, 32'h17FFFFFF});
        vecs.push_back('{"cbz_neg2", 4'hC,  5'd5,  5'd0,  5'd0, 26'h3FFFFFE,   1'b0, 32'hB4FFFFC5});
        vecs.push_back('{"op_e",     4'hE,  5'd1,  5'd1,  5'd1, 26'd0,         1'b1, 32'h0});
        vecs.push_back('{"op_f",     4'hF,  5'd1,  5'd1,  5'd1, 26'd0,         1'b1, 32'h0});
        vecs.push_back('{"and_imm",  4'h0,  5'd0,  5'd0,  5'd0, 26'h3FFFFFF,   1'b0, 32'h8A000000});
        vecs.push_back('{"sub",      4'h3,  5'd1,  5'd2,  5'd3, 26'd0,         1'b0, 32'hCB030041});
        vecs.push_back('{"orr_31",   4'h2,  5'd31, 5'd31, 5'd31, 26'd0,        1'b0, 32'hAA1F03FF});
        vecs.push_back('{"lsl4",     4'h4,  5'd1,  5'd2,  5'd7, 26'd4,         1'b0, 32'hD3601041});
        vecs.push_back('{"lsl64",    4'h4,  5'd1,  5'd2,  5'd7, 26'd64,        1'b1, 32'h0});
        vecs.push_back('{"subi_max", 4'h6,  5'd2,  5'd3,  5'd0, 26'hFFF,       1'b0, 32'hD13FFC62});
        vecs.push_back('{"andi0",    4'h7,  5'd0,  5'd0,  5'd0, 26'd0,         1'b0, 32'h92000000});
        vecs.push_back('{"orri",     4'h8,  5'd1,  5'd0,  5'd9, 26'd0,         1'b0, 32'hB2000001});
        vecs.push_back('{"stur_m1",  4'hA,  5'd3,  5'd4,  5'd0, 26'h3FFFFFF,   1'b0, 32'hF81FF083});
        vecs.push_back('{"ldur_256", 4'h9,  5'd0,  5'd0,  5'd0, 26'd256,       1'b1, 32'h0});
        vecs.push_back('{"ldur_255", 4'h9,  5'd0,  5'd0,  5'd0, 26'd255,       1'b0, 32'hF84FF000});
        vecs.push_back('{"cbnz_max", 4'hD,  5'd0,  5'd0,  5'd0, 26'h3FFFF,     1'b0, 32'hB57FFFE0});
        vecs.push_back('{"cbz_ovf",  4'hC,  5'd0,  5'd0,  5'd0, 26'h40000,     1'b1, 32'h0});
        vecs.push_back('{"b_zero",   4'hB,  5'd0,  5'd0,  5'd0, 26'd0,         1'b0, 32'h14000000});

        repeat (2) @(posedge clk);
        @(negedge clk);
        step("reset", 1'b1, 1'b0, 1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0, 32'd0);
        idle("idle_no_ready");
        step("valid_in_idle", 1'b0, 1'b0, 1'b1, 4'h1, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0, 32'h8B030041);
        step("start", 1'b0, 1'b1, 1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].name, 1'b0, 1'b0, 1'b1, vecs[i].op, vecs[i].rd,
                 vecs[i].rn, vecs[i].rm, vecs[i].imm, vecs[i].bad, vecs[i].word);
        end

        // start with in_valid: previous write completes, new request ignored
        step("pre_start_add", 1'b0, 1'b0, 1'b1, 4'h1, 5'd4, 5'd5, 5'd6, 26'd0, 1'b0, 32'h8B0600A4);
        step("start_valid", 1'b0, 1'b1, 1'b1, 4'h1, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0, 32'h8B030041);
        idle("gap");

        // fill all 256 words back to back
        for (int i = 0; i < 256; i++) begin
            logic [25:0] bi;
            bi = 26'(i);
            step("fill", 1'b0, 1'b0, 1'b1, 4'hB, 5'd0, 5'd0, 5'd0, bi, 1'b0, 32'h14000000 | 32'(i));
        end
        step("valid_257", 1'b0, 1'b0, 1'b1, 4'hB, 5'd0, 5'd0, 5'd0, 26'd7, 1'b0, 32'h14000007);
        idle("full_hold");

        // start while FULL, with in_valid, then a write at address 0
        step("start_full", 1'b0, 1'b1, 1'b1, 4'h1, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0, 32'h8B030041);
        step("after_full", 1'b0, 1'b0, 1'b1, 4'h1, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0, 32'h8B030041);
        step("illegal_e", 1'b0, 1'b0, 1'b1, 4'hE, 5'd0, 5'd0, 5'd0, 26'd0, 1'b1, 32'h0);

        // reset coincident with a handshake cancels the write
        step("reset_cancel", 1'b1, 1'b0, 1'b1, 4'h1, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0, 32'h8B030041);
        idle("post_reset");
        step("reset_over_start", 1'b1, 1'b1, 1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0, 32'd0);
        idle("post_reset2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
